adma_dst_mem_slave: RTL and testbench



---
 rtl/adma_dst_mem_slave.sv | 162 ++++++++++++++++
 tb/tb_adma_dst_mem_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adma_dst_mem_slave.sv
// AXI4 write-only responder memory for a DMA destination port, with side read-back.
// Optional ADMA_DST_MEM_BP_EN: LFSR-driven W backpressure.
module adma_dst_mem_slave #(
  parameter int                DATA_W           = 256,
  parameter int                ADDR_W           = 32,
  parameter int                MST_ID_W         = 5,
  parameter int                TRANS_DATA_LEN_W = 8,
  parameter int                TRANS_RESP_W     = 2,
  parameter logic [ADDR_W-1:0] MEM_BASE         = 32'h0000_0000,
  parameter int                MEM_DEPTH        = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [MST_ID_W-1:0]          s_awid_i,
  input  logic [ADDR_W-1:0]            s_awaddr_i,
  input  logic [TRANS_DATA_LEN_W-1:0]  s_awlen_i,
  input  logic [1:0]                   s_awburst_i,
  input  logic                         s_awvalid_i,
  output logic                         s_awready_o,
  input  logic [DATA_W-1:0]            s_wdata_i,
  input  logic                         s_wlast_i,
  input  logic                         s_wvalid_i,
  output logic                         s_wready_o,
  output logic [MST_ID_W-1:0]          s_bid_o,
  output logic [TRANS_RESP_W-1:0]      s_bresp_o,
  output logic                         s_bvalid_o,
  input  logic                         s_bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]            rd_data_o
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int OFF_SH = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                        state_q, state_d;
  logic [MST_ID_W-1:0]           awid_q, awid_d, bid_q, bid_d;
  logic [TRANS_DATA_LEN_W-1:0]   awlen_q, awlen_d, beat_q, beat_d;
  logic [1:0]                    burst_q, burst_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;
  logic                          addr_ok_q, addr_ok_d;
  logic                          over_q, over_d;
  logic                          err_q, err_d;
  logic [TRANS_RESP_W-1:0]       bresp_q, bresp_d;
  logic                          w_hs, beat_legal, beat_in_range, beat_err, mem_we;
  logic [DATA_W-1:0]             mem [MEM_DEPTH];
  logic [DATA_W-1:0]             rd_data_q;

`ifdef ADMA_DST_MEM_BP_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4; bit 0 gates W acceptance.
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end

  assign s_wready_o = (state_q == DATA) & lfsr_q[0];
`else
  assign s_wready_o = (state_q == DATA);
`endif

  assign s_awready_o = (state_q == IDLE);
  assign s_bvalid_o  = (state_q == RESP);
  assign s_bid_o     = bid_q;
  assign s_bresp_o   = bresp_q;
  assign rd_data_o   = rd_data_q;

  assign w_hs          = s_wvalid_i & s_wready_o;
  assign beat_legal    = ~burst_q[1];
  assign beat_in_range = addr_ok_q & (idx_q < ADDR_W'(MEM_DEPTH));
  assign mem_we        = w_hs & beat_legal & beat_in_range & ~over_q;
  // Error when WLAST does not coincide with beat awlen; over_q covers beats past awlen.
  assign beat_err      = ~beat_legal | ~beat_in_range | over_q |
                         (s_wlast_i ^ (beat_q == awlen_q));

  always_comb begin
    state_d   = state_q;
    awid_d    = awid_q;
    awlen_d   = awlen_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    addr_ok_d = addr_ok_q;
    beat_d    = beat_q;
    over_d    = over_q;
    err_d     = err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        if (s_awvalid_i) begin
          awid_d    = s_awid_i;
          awlen_d   = s_awlen_i;
          burst_d   = s_awburst_i;
          idx_d     = (s_awaddr_i - MEM_BASE) >> OFF_SH;
          addr_ok_d = (s_awaddr_i >= MEM_BASE);
          beat_d    = '0;
          over_d    = 1'b0;
          err_d     = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d = err_q | beat_err;
          if (burst_q == 2'b01) idx_d = idx_q + 1'b1;
          if (!s_wlast_i) begin
            if (beat_q == awlen_q) over_d = 1'b1;
            else                   beat_d = beat_q + 1'b1;
          end else begin
            bid_d   = awid_q;
            bresp_d = (err_q | beat_err) ? TRANS_RESP_W'(2'b10) : '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (s_bready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      awid_q    <= '0;
      awlen_q   <= '0;
      burst_q   <= '0;
      idx_q     <= '0;
      addr_ok_q <= 1'b0;
      beat_q    <= '0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      awid_q    <= awid_d;
      awlen_q   <= awlen_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      addr_ok_q <= addr_ok_d;
      beat_q    <= beat_d;
      over_q    <= over_d;
      err_q     <= err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rd_data_q <= mem[rd_addr_i];
    end
  end

  // Storage is deliberately not reset so contents survive a mid-burst reset.
  always_ff @(posedge aclk) begin
    if (mem_we) mem[idx_q[IDX_W-1:0]] <= s_wdata_i;
  end

endmodule

// File: tb/tb_adma_dst_mem_slave.sv
// Bench for adma_dst_mem_slave: directed and random AXI write bursts against a
// word-array reference model, checked through the B channel and read-back port.
module tb_adma_dst_mem_slave;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 5;
  localparam int LEN_W  = 8;
  localparam int RESP_W = 2;
  localparam int DEPTH  = 256;
  localparam logic [ADDR_W-1:0] BASE = 32'h0000_0000;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [ID_W-1:0]   s_awid_i = '0;
  logic [ADDR_W-1:0] s_awaddr_i = '0;
  logic [LEN_W-1:0]  s_awlen_i = '0;
  logic [1:0]        s_awburst_i = '0;
  logic              s_awvalid_i = 1'b0;
  logic              s_awready_o;
  logic [DATA_W-1:0] s_wdata_i = '0;
  logic              s_wlast_i = 1'b0;
  logic              s_wvalid_i = 1'b0;
  logic              s_wready_o;
  logic [ID_W-1:0]   s_bid_o;
  logic [RESP_W-1:0] s_bresp_o;
  logic              s_bvalid_o;
  logic              s_bready_i = 1'b0;
  logic [7:0]        rd_addr_i = '0;
  logic [DATA_W-1:0] rd_data_o;

  adma_dst_mem_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i),
    .s_awburst_i(s_awburst_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wlast_i(s_wlast_i), .s_wvalid_i(s_wvalid_i),
    .s_wready_o(s_wready_o), .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DATA_W-1:0] model [DEPTH];

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_word(input int w);
    rd_addr_i = w[7:0];
    step();
    chk($sformatf("mem[%0d]", w), rd_data_o, model[w]);
  endtask

  // One AW/W/B transaction; wl is the beat index carrying WLAST.
  task automatic burst(input int id, input int word, input int len, input logic [1:0] bt,
                       input int wl, input int hold);
    logic err;
    int cyc, guard, idx;
    logic [DATA_W-1:0] d;
    err = bt[1] || (wl != len);
    s_awid_i    = id[ID_W-1:0];
    s_awaddr_i  = BASE + ADDR_W'(word * (DATA_W / 8));
    s_awlen_i   = len[LEN_W-1:0];
    s_awburst_i = bt;
    s_awvalid_i = 1'b1;
    guard = 0;
    while (!s_awready_o && guard < 100) begin step(); guard++; end
    if (guard >= 100) chk("aw_timeout", 1, 0);
    step();
    s_awvalid_i = 1'b0;
    cyc = 1;
    chk("awready_in_data", s_awready_o, 1'b0);
    for (int b = 0; b <= wl; b++) begin
      d = rnd_data();
      s_wdata_i  = d;
      s_wvalid_i = 1'b1;
      s_wlast_i  = (b == wl);
      guard = 0;
      while (!s_wready_o && guard < 200) begin step(); cyc++; guard++; end
      if (guard >= 200) chk("w_timeout", 1, 0);
      idx = word + ((bt == 2'b01) ? b : 0);
      if (!bt[1]) begin
        if (idx >= DEPTH) err = 1'b1;
        else if (b <= len) model[idx] = d;
      end
      step();
      cyc++;
    end
    s_wvalid_i = 1'b0;
    s_wlast_i  = 1'b0;
    guard = 0;
    while (!s_bvalid_o && guard < 100) begin step(); cyc++; guard++; end
    if (guard >= 100) chk("b_timeout", 1, 0);
`ifndef ADMA_DST_MEM_BP_EN
    chk("b_latency", cyc, wl + 2);
`endif
    chk("bid", s_bid_o, id[ID_W-1:0]);
    chk("bresp", s_bresp_o, err ? 2'b10 : 2'b00);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bvalid_hold", s_bvalid_o, 1'b1);
      chk("bid_hold", s_bid_o, id[ID_W-1:0]);
      chk("bresp_hold", s_bresp_o, err ? 2'b10 : 2'b00);
      chk("awready_hold", s_awready_o, 1'b0);
    end
    s_bready_i = 1'b1;
    step();
    s_bready_i = 1'b0;
    chk("awready_after_b", s_awready_o, 1'b1);
    chk("bvalid_after_b", s_bvalid_o, 1'b0);
    $display("burst id=%0d word=%0d len=%0d bt=%0d wlast@%0d hold=%0d err=%0d", id, word, len, bt, wl, hold, err);
  endtask

  initial begin
    int word, len, wl, r, q;
    logic [1:0] bt;
    logic [DATA_W-1:0] d;

    // Reset values
    step(); step();
    chk("rst_awready", s_awready_o, 1'b1);
    chk("rst_wready", s_wready_o, 1'b0);
    chk("rst_bvalid", s_bvalid_o, 1'b0);
    chk("rst_bid", s_bid_o, '0);
    chk("rst_bresp", s_bresp_o, '0);
    chk("rst_rd_data", rd_data_o, '0);
    aresetn = 1'b1;
    step();

    // Fill whole memory so the model is fully known
    burst(0, 0, 255, 2'b01, 255, 0);

    burst(5, 2, 3, 2'b01, 3, 0);
    for (int w = 2; w <= 5; w++) check_word(w);

    burst(1, 2, 3, 2'b01, 1, 0);
    for (int w = 2; w <= 6; w++) check_word(w);

    burst(2, DEPTH - 2, 3, 2'b01, 3, 0);
    check_word(DEPTH - 2); check_word(DEPTH - 1); check_word(0); check_word(1);

    burst(3, 8, 3, 2'b10, 3, 0);
    for (int w = 8; w <= 11; w++) check_word(w);

    burst(7, 12, 1, 2'b01, 1, 5);
    burst(4, 14, 3, 2'b00, 3, 0);
    check_word(14); check_word(15);
    burst(6, 16, 1, 2'b01, 3, 0);
    for (int w = 16; w <= 19; w++) check_word(w);

    for (int n = 0; n < 24; n++) begin
      word = $urandom_range(0, DEPTH + 3);
      len  = $urandom_range(0, 7);
      r    = $urandom_range(0, 9);
      bt   = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      q    = $urandom_range(0, 5);
      wl   = (q < 4) ? len : (q == 4) ? $urandom_range(0, len) : len + $urandom_range(1, 2);
      burst($urandom_range(0, 31), word, len, bt, wl, $urandom_range(0, 3));
    end

    // Reset asserted mid-DATA: written beats remain, outputs return to reset values
    s_awid_i = 5'd9; s_awaddr_i = BASE + ADDR_W'(20 * (DATA_W / 8));
    s_awlen_i = 8'd5; s_awburst_i = 2'b01; s_awvalid_i = 1'b1;
    step();
    s_awvalid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = rnd_data();
      s_wdata_i = d; s_wvalid_i = 1'b1;
      while (!s_wready_o) step();
      model[20 + b] = d;
      step();
    end
    s_wvalid_i = 1'b0;
    chk("mid_awready", s_awready_o, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("mrst_awready", s_awready_o, 1'b1);
    chk("mrst_wready", s_wready_o, 1'b0);
    chk("mrst_bvalid", s_bvalid_o, 1'b0);
    chk("mrst_bid", s_bid_o, '0);
    chk("mrst_bresp", s_bresp_o, '0);
    chk("mrst_rd_data", rd_data_o, '0);
    step();
    aresetn = 1'b1;
    step();
    $display("reset mid-burst after 2 beats at word 20");
    check_word(20); check_word(21);

    for (int w = 0; w < DEPTH; w++) check_word(w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
